// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering: lane masks, store replication, load extraction/extension
// and access legality for one memory access.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_f3,
    input  logic [1:0]  i_off,
    input  logic        i_is_load,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_lane,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_ldata,
    output logic        o_misalign,
    output logic        o_illegal
);

    logic [31:0] w_shift;

    assign w_shift = i_rword >> {i_off, 3'b000};

    always_comb begin
        o_lane      = 4'b0000;
        o_wdata_rep = i_wdata;
        o_ldata     = 32'h0;
        o_misalign  = 1'b0;
        o_illegal   = 1'b0;
        case (i_f3)
            F3_B, F3_BU: begin
                o_lane      = 4'b0001 << i_off;
                o_wdata_rep = {4{i_wdata[7:0]}};
                o_ldata     = (i_f3 == F3_B) ? {{24{w_shift[7]}}, w_shift[7:0]}
                                             : {24'h0, w_shift[7:0]};
                o_illegal   = (i_f3 == F3_BU) && !i_is_load;
            end
            F3_H, F3_HU: begin
                o_lane      = 4'b0011 << i_off;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_ldata     = (i_f3 == F3_H) ? {{16{w_shift[15]}}, w_shift[15:0]}
                                             : {16'h0, w_shift[15:0]};
                o_misalign  = i_off[0];
                o_illegal   = (i_f3 == F3_HU) && !i_is_load;
            end
            F3_W: begin
                o_lane     = 4'b1111;
                o_ldata    = w_shift;
                o_misalign = (i_off != 2'b00);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: request/valid handshake, pipeline stall,
// aligned load return, access and timeout error pulses.
//
// state | meaning
// IDLE  | waiting for a valid load/store strobe from the decoder
// REQ   | mem_req asserted for exactly one cycle
// WAIT  | waiting for mem_valid, bounded by TIMEOUT
// DONE  | access retired, pipeline advances on this edge
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [3:0]        be,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              acc_err,
    output logic              tmo_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_valid,
    input  logic [31:0]       mem_rdata
);

    state_e            r_state, w_next;
    logic [7:0]        r_cnt;
    logic              r_load;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [31:0]       r_rdata;
    logic              r_acc_err, r_tmo_err, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;

    logic              w_valid_op, w_bad, w_tmo, w_in_idle;
    logic [2:0]        w_f3;
    logic [1:0]        w_off;
    logic              w_is_load, w_misalign, w_illegal;
    logic [3:0]        w_lane;
    logic [31:0]       w_wdata_rep, w_ldata;

    assign w_valid_op = cs && (rd_n != wr_n);
    assign w_in_idle  = (r_state == IDLE);
    // Decode live strobes while idle, latched ones once the access is in flight.
    assign w_f3       = w_in_idle ? funct3 : r_f3;
    assign w_off      = w_in_idle ? addr[1:0] : r_off;
    assign w_is_load  = w_in_idle ? !rd_n : r_load;
    assign w_bad      = w_misalign || w_illegal;
    assign w_tmo      = (r_state == WAIT) && !mem_valid && (r_cnt == 8'(TIMEOUT));

    dmem_align u_align (
        .i_f3        (w_f3),
        .i_off       (w_off),
        .i_is_load   (w_is_load),
        .i_wdata     (wdata),
        .i_rword     (mem_rdata),
        .o_lane      (w_lane),
        .o_wdata_rep (w_wdata_rep),
        .o_ldata     (w_ldata),
        .o_misalign  (w_misalign),
        .o_illegal   (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_valid_op) w_next = w_bad ? DONE : REQ;
            REQ:  w_next = mem_valid ? DONE : WAIT;
            WAIT: if (mem_valid || w_tmo) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (r_state == REQ);
        stall   = (r_state == REQ) || (r_state == WAIT) || (w_in_idle && w_valid_op);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= 8'd0;
            r_load      <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_rdata     <= 32'h0;
            r_acc_err   <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
        end else begin
            r_acc_err <= 1'b0;
            r_tmo_err <= 1'b0;
            r_cnt     <= (r_state == REQ) ? 8'd1 : (r_state == WAIT) ? r_cnt + 8'd1 : 8'd0;
            case (r_state)
                IDLE: if (w_valid_op) begin
                    r_load <= !rd_n;
                    r_f3   <= funct3;
                    r_off  <= addr[1:0];
                    if (w_bad) begin
                        r_acc_err <= 1'b1;
                        if (!rd_n) r_rdata <= 32'h0;
                    end else begin
                        r_mem_we    <= !wr_n;
                        r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        r_mem_be    <= w_lane & be;
                        r_mem_wdata <= w_wdata_rep;
                    end
                end
                REQ, WAIT: begin
                    if (mem_valid) begin
                        if (r_load) r_rdata <= w_ldata;
                    end else if (w_tmo) begin
                        r_tmo_err <= 1'b1;
                        if (r_load) r_rdata <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign acc_err   = r_acc_err;
    assign tmo_err   = r_tmo_err;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: driver queues expected requests/completions,
// a monitor checks them as the DUT presents mem_req and completes accesses.
module tb_dmem_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        acc;
        logic        tmo;
        logic [7:0]  stall_cyc;
    } done_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
    logic [3:0]  be = 4'b1111;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        stall, acc_err, tmo_err, mem_req, mem_we, mem_valid;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'h0;

    logic        model_valid = 1'b0, force_valid = 1'b0;
    int          mem_delay = -1;
    int          mem_cnt = 0;
    bit          mem_active = 1'b0;

    int          n_total = 0, n_pass = 0;
    req_t        q_req[$];
    done_t       q_done[$];

    assign mem_valid = model_valid | force_valid;

    dmem_ctrl #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .rd_n(rd_n), .wr_n(wr_n), .be(be),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .acc_err(acc_err), .tmo_err(tmo_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory responder: mem_valid arrives mem_delay cycles after the REQ cycle (-1 = never).
    always begin
        @(negedge clk);
        #1;
        model_valid = 1'b0;
        if (!rst_n) mem_active = 1'b0;
        else if (mem_req) begin
            mem_active = 1'b1;
            mem_cnt = 0;
        end else if (mem_active) mem_cnt++;
        if (mem_active && mem_delay >= 0 && mem_cnt == mem_delay) begin
            model_valid = 1'b1;
            mem_active = 1'b0;
        end
    end

    initial begin : monitor
        logic  prev_stall;
        int    stall_cyc;
        bit    spurious;
        req_t  er;
        done_t ed;
        prev_stall = 1'b0;
        stall_cyc  = 0;
        spurious   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                stall_cyc  = 0;
                continue;
            end
            if (mem_req) begin
                if (q_req.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
                else begin
                    er = q_req.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, er.we});
                    chk("mem_addr", mem_addr, er.addr);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, er.be});
                    chk("mem_wdata", mem_wdata, er.wdata);
                end
            end
            if (prev_stall && !stall) begin
                if (q_done.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    ed = q_done.pop_front();
                    chk("rdata", rdata, ed.rdata);
                    chk("acc_err", {31'd0, acc_err}, {31'd0, ed.acc});
                    chk("tmo_err", {31'd0, tmo_err}, {31'd0, ed.tmo});
                    chk("stall_cycles", stall_cyc, {24'd0, ed.stall_cyc});
                    chk("stray_err_pulse", {31'd0, spurious}, 32'd0);
                end
                spurious = 1'b0;
            end else if (acc_err || tmo_err) spurious = 1'b1;
            stall_cyc  = stall ? stall_cyc + 1 : 0;
            prev_stall = stall;
        end
    end

    task automatic access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int dly, input logic [31:0] word,
                          input bit exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input bit exp_acc, input bit exp_tmo,
                          input int exp_stall);
        bit finished;
        finished = 1'b0;
        @(negedge clk);
        mem_delay = dly;
        mem_rdata = word;
        funct3 = f3; addr = a; wdata = wd; be = 4'b1111;
        rd_n = !ld; wr_n = ld; cs = 1'b1;
        if (exp_req) q_req.push_back('{we: !ld, addr: {a[31:2], 2'b00}, be: exp_be, wdata: exp_wd});
        q_done.push_back('{rdata: exp_rd, acc: exp_acc, tmo: exp_tmo, stall_cyc: 8'(exp_stall)});
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!stall) begin
                finished = 1'b1;
                break;
            end
        end
        chk("access_completes", {31'd0, finished}, 32'd1);
        @(negedge clk);
        cs = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_acc_err"}, {31'd0, acc_err}, 32'd0);
        chk({tag, "_tmo_err"}, {31'd0, tmo_err}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        //     ld f3      addr          wdata         dly word          req be       mem_wdata     rdata         acc tmo stall
        access(1, 3'b010, 32'h0000_0100, 32'h0,        0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0, 0, 2);
        access(1, 3'b000, 32'h0000_0103, 32'h0,        0, 32'h80FF_FFFF, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 0, 0, 2);
        access(1, 3'b100, 32'h0000_0103, 32'h0,        0, 32'h80FF_FFFF, 1, 4'b1000, 32'h0,        32'h0000_0080, 0, 0, 2);
        access(0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h0,        1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080, 0, 0, 5);
        access(0, 3'b000, 32'h0000_0101, 32'h0000_00A5, 1, 32'h0,        1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0080, 0, 0, 3);
        access(1, 3'b001, 32'h0000_0102, 32'h0,        2, 32'h8001_7FFF, 1, 4'b1100, 32'h0,        32'hFFFF_8001, 0, 0, 4);
        access(1, 3'b101, 32'h0000_0102, 32'h0,        0, 32'h8001_7FFF, 1, 4'b1100, 32'h0,        32'h0000_8001, 0, 0, 2);
        access(1, 3'b010, 32'h0000_0300, 32'h0,       -1, 32'h0,        1, 4'b1111, 32'h0,        32'h0,         0, 1, 6);
        access(1, 3'b010, 32'h0000_0104, 32'h0,        4, 32'h1357_9BDF, 1, 4'b1111, 32'h0,        32'h1357_9BDF, 0, 0, 6);
        access(0, 3'b011, 32'h0000_0200, 32'h5555_5555, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h1357_9BDF, 1, 0, 1);
        access(1, 3'b010, 32'h0000_0101, 32'h0,        0, 32'hFFFF_FFFF, 0, 4'b0000, 32'h0,        32'h0,         1, 0, 1);
        access(1, 3'b010, 32'h0000_0108, 32'h0,        0, 32'hCAFE_F00D, 1, 4'b1111, 32'h0,        32'hCAFE_F00D, 0, 0, 2);
        access(1, 3'b110, 32'h0000_0100, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,         1, 0, 1);
        access(1, 3'b001, 32'h0000_0201, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,         1, 0, 1);

        // Reset while waiting on memory, then a stale completion arrives.
        @(negedge clk);
        mem_delay = -1;
        funct3 = 3'b010; addr = 32'h0000_0400; wdata = 32'h0;
        rd_n = 1'b0; wr_n = 1'b1; cs = 1'b1;
        q_req.push_back('{we: 1'b0, addr: 32'h0000_0400, be: 4'b1111, wdata: 32'h0});
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; cs = 1'b0; rd_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        mem_rdata = 32'hBAD0_BAD0;
        force_valid = 1'b1;
        @(negedge clk);
        force_valid = 1'b0;
        #1;
        check_reset_outputs("late_valid");
        repeat (3) @(negedge clk);
        #3;
        chk("stall_after_late_valid", {31'd0, stall}, 32'd0);
        chk("req_queue_drained", q_req.size(), 32'd0);
        chk("done_queue_drained", q_done.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
